// File: rtl/label_pkg.sv
// Shared constants and state encoding for the connected-component label resolver.
package label_pkg;

  localparam int IMG_W      = 320;
  localparam int IMG_H      = 240;
  localparam int LABEL_W    = 6;
  localparam int FIFO_DEPTH = 8;
  localparam int NUM_PIX    = IMG_W * IMG_H;

  // state   | meaning
  // IDLE    | first pass running, merge pairs buffered only
  // DRAIN   | apply buffered merges to the equivalence table
  // FLATTEN | point every label straight at its class root
  // SCAN    | stream label RAM through the table
  // DONE    | one-cycle completion, table back to identity
  typedef enum logic [2:0] {IDLE, DRAIN, FLATTEN, SCAN, DONE} state_t;

endpackage

// File: rtl/label_merge_fifo.sv
// Small synchronous FIFO holding pending {hi, lo} merge pairs.
module label_merge_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 12
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (i_pop)  r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/label_resolve.sv
// Second-pass label resolver: collects merge pairs, builds a min-root equivalence
// table, flattens it and remaps every pixel label read from the label RAM.
module label_resolve #(
  parameter int IMG_W      = label_pkg::IMG_W,
  parameter int IMG_H      = label_pkg::IMG_H,
  parameter int LABEL_W    = label_pkg::LABEL_W,
  parameter int FIFO_DEPTH = label_pkg::FIFO_DEPTH
) (
  input  logic               iclk,
  input  logic               irst,
  input  logic               iResolve,
  input  logic [LABEL_W-1:0] iMerge_label_1,
  input  logic [LABEL_W-1:0] iMerge_label_2,
  input  logic               iLabeling_finish,
  output logic               read_en,
  output logic [16:0]        read_addr,
  input  logic [LABEL_W-1:0] iRam_data,
  output logic [LABEL_W-1:0] oData,
  output logic               oData_VAL,
  output logic               oBusy,
  output logic               oDone,
  output logic               oOverflow
);

  import label_pkg::*;

  localparam int                 NLAB      = 2 ** LABEL_W;
  localparam logic [16:0]        LAST_ADDR = 17'(IMG_W * IMG_H - 1);
  localparam logic [LABEL_W-1:0] LAST_LAB  = LABEL_W'(NLAB - 1);

  state_t               r_state, w_state_nxt;
  logic [LABEL_W-1:0]   r_parent [NLAB];
  logic                 r_fin_q, r_eng_busy, r_val, r_ovf, r_read_en;
  logic [LABEL_W-1:0]   r_lo, r_hi, r_idx;
  logic [16:0]          r_read_addr;

  logic [LABEL_W-1:0]   w_lo_in, w_hi_in, w_p;
  logic [2*LABEL_W-1:0] w_fifo_q;
  logic                 w_pair_ok, w_accept_st, w_push, w_pop, w_full, w_empty, w_start;

  assign w_lo_in     = (iMerge_label_1 < iMerge_label_2) ? iMerge_label_1 : iMerge_label_2;
  assign w_hi_in     = (iMerge_label_1 < iMerge_label_2) ? iMerge_label_2 : iMerge_label_1;
  assign w_pair_ok   = iResolve && (w_lo_in != '0) && (w_lo_in != w_hi_in);
  assign w_accept_st = (r_state == IDLE) || (r_state == DRAIN);
  assign w_pop       = (r_state == DRAIN) && !r_eng_busy && !w_empty;
  assign w_push      = w_accept_st && w_pair_ok && (!w_full || w_pop);
  assign w_p         = r_parent[r_hi];
  assign w_start     = iLabeling_finish && !r_fin_q;

  label_merge_fifo #(.DEPTH(FIFO_DEPTH), .W(2 * LABEL_W)) u_fifo (
    .i_clk   (iclk),
    .i_rst   (irst),
    .i_push  (w_push),
    .i_data  ({w_hi_in, w_lo_in}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_q),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = DRAIN;
      DRAIN:   if (w_empty && !r_eng_busy && !w_push) w_state_nxt = FLATTEN;
      FLATTEN: if (r_idx == LAST_LAB) w_state_nxt = SCAN;
      SCAN:    if (!r_read_en && r_val) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_state     <= IDLE;
      r_fin_q     <= 1'b1;  // a finish level present at reset release must not start a run
      r_eng_busy  <= 1'b0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_idx       <= '0;
      r_read_en   <= 1'b0;
      r_read_addr <= '0;
      r_val       <= 1'b0;
      r_ovf       <= 1'b0;
      for (int i = 0; i < NLAB; i++) r_parent[i] <= LABEL_W'(i);
    end else begin
      r_state <= w_state_nxt;
      r_fin_q <= iLabeling_finish;
      r_val   <= r_read_en;
      if ((iResolve && !w_accept_st) || (w_pair_ok && w_accept_st && !w_push)) r_ovf <= 1'b1;

      if (r_state == DRAIN) begin
        if (r_eng_busy) begin
          if (w_p == r_hi) begin
            r_parent[r_hi] <= r_lo;
            r_eng_busy     <= 1'b0;
          end else if (w_p == r_lo) begin
            r_eng_busy <= 1'b0;
          end else if (w_p < r_lo) begin
            r_hi <= r_lo;
            r_lo <= w_p;
          end else begin
            r_parent[r_hi] <= r_lo;
            r_hi           <= w_p;
          end
        end else if (w_pop) begin
          r_lo       <= w_fifo_q[LABEL_W-1:0];
          r_hi       <= w_fifo_q[2*LABEL_W-1:LABEL_W];
          r_eng_busy <= 1'b1;
        end
        if (w_state_nxt == FLATTEN) r_idx <= LABEL_W'(1);
      end

      if (r_state == FLATTEN) begin
        r_parent[r_idx] <= r_parent[r_parent[r_idx]];
        r_idx           <= r_idx + 1'b1;
      end

      if (r_state == FLATTEN && w_state_nxt == SCAN) begin
        r_read_en   <= 1'b1;
        r_read_addr <= '0;
      end else if (r_read_en) begin
        if (r_read_addr == LAST_ADDR) begin
          r_read_en   <= 1'b0;
          r_read_addr <= '0;
        end else begin
          r_read_addr <= r_read_addr + 1'b1;
        end
      end

      if (r_state == DONE) begin
        for (int i = 0; i < NLAB; i++) r_parent[i] <= LABEL_W'(i);
      end
    end
  end

  assign read_en   = r_read_en;
  assign read_addr = r_read_addr;
  assign oData_VAL = r_val;
  assign oData     = r_val ? r_parent[iRam_data] : '0;
  assign oBusy     = (r_state != IDLE);
  assign oDone     = (r_state == DONE);
  assign oOverflow = r_ovf;

endmodule

// File: tb/tb_label_resolve.sv
// Directed bench for label_resolve: component-minimum model of accepted merges,
// per-cycle comparison of the scan stream, plus literal spot checks.
module tb_label_resolve;
  import label_pkg::*;

  localparam int NLAB = 2 ** LABEL_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               resolve;
  logic [LABEL_W-1:0] lab1, lab2;
  logic               finish;
  logic               read_en;
  logic [16:0]        read_addr;
  logic [LABEL_W-1:0] ram_q;
  logic [LABEL_W-1:0] odata;
  logic               oval, obusy, odone, oovf;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  label_resolve dut (
    .iclk             (clk),
    .irst             (rst),
    .iResolve         (resolve),
    .iMerge_label_1   (lab1),
    .iMerge_label_2   (lab2),
    .iLabeling_finish (finish),
    .read_en          (read_en),
    .read_addr        (read_addr),
    .iRam_data        (ram_q),
    .oData            (odata),
    .oData_VAL        (oval),
    .oBusy            (obusy),
    .oDone            (odone),
    .oOverflow        (oovf)
  );

  // Label RAM preloaded with addr % 64, one-cycle read latency.
  always @(posedge clk) begin
    if (read_en) ram_q <= LABEL_W'(int'(read_addr) % NLAB);
  end

  task automatic check(input string nm, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: accepted pairs, and each label's class minimum.
  int pa[$];
  int pb[$];
  int n_acc;
  int root_of[NLAB];

  function automatic void model_clear();
    pa.delete();
    pb.delete();
    n_acc = 0;
    for (int i = 0; i < NLAB; i++) root_of[i] = i;
  endfunction

  function automatic void model_compute();
    bit ch;
    int m;
    for (int i = 0; i < NLAB; i++) root_of[i] = i;
    do begin
      ch = 0;
      for (int k = 0; k < pa.size(); k++) begin
        m = (root_of[pa[k]] < root_of[pb[k]]) ? root_of[pa[k]] : root_of[pb[k]];
        if (root_of[pa[k]] != m || root_of[pb[k]] != m) ch = 1;
        root_of[pa[k]] = m;
        root_of[pb[k]] = m;
      end
    end while (ch);
  endfunction

  task automatic send_pair(input int a, input int b);
    resolve = 1'b1;
    lab1 = LABEL_W'(a);
    lab2 = LABEL_W'(b);
    if (a != 0 && b != 0 && a != b) begin
      if (n_acc < FIFO_DEPTH) begin
        pa.push_back(a);
        pb.push_back(b);
      end
      n_acc++;
    end
    @(negedge clk);
    resolve = 1'b0;
  endtask

  // Per-cycle comparison of the scan stream against the model.
  int exp_addr = 0;
  bit pend_val = 0;
  int pend_data = 0;
  bit pend_last = 0;
  bit done_exp = 0;
  int val_count = 0;
  int done_count = 0;

  always @(negedge clk) begin
    if (oval) val_count++;
    if (odone) done_count++;
    if (rst) begin
      check("rst_val", oval, 0);
      check("rst_done", odone, 0);
      pend_val = 0;
      done_exp = 0;
      exp_addr = 0;
    end else begin
      check("data_val", oval, pend_val);
      if (pend_val) check("data", odata, pend_data);
      check("done", odone, done_exp);
      done_exp = pend_val && pend_last;
      if (exp_addr != 0) check("read_en_run", read_en, 1);
      if (read_en) begin
        check("read_addr", read_addr, exp_addr);
        pend_val  = 1;
        pend_data = root_of[exp_addr % NLAB];
        pend_last = (exp_addr == NUM_PIX - 1);
        exp_addr  = pend_last ? 0 : exp_addr + 1;
      end else begin
        pend_val = 0;
      end
    end
  end

  task automatic wait_addr(input int target);
    bit hit = 0;
    for (int i = 0; i < NUM_PIX + 1000; i++) begin
      @(negedge clk);
      if (read_en && int'(read_addr) == target) begin
        hit = 1;
        break;
      end
    end
    if (!hit) check("timeout_addr", 0, 1);
  endtask

  task automatic pin_data(input int addr, input int exp);
    wait_addr(addr);
    @(negedge clk);
    check("pin_val", oval, 1);
    check("pin_data", odata, exp);
  endtask

  task automatic mid_reset(input int addr);
    int dc;
    wait_addr(addr);
    #1 rst = 1'b1;
    #1;
    check("rst_read_en", read_en, 0);
    check("rst_read_addr", read_addr, 0);
    check("rst_odata", odata, 0);
    check("rst_oval", oval, 0);
    check("rst_busy", obusy, 0);
    check("rst_done_now", odone, 0);
    check("rst_ovf", oovf, 0);
    finish  = 1'b0;
    resolve = 1'b0;
    dc = done_count;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_busy", obusy, 0);
    check("post_rst_no_done", done_count, dc);
    model_clear();
  endtask

  initial begin
    int vc0, dc0;
    bit got;
    rst = 1'b1; resolve = 1'b0; lab1 = '0; lab2 = '0; finish = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("init_busy", obusy, 0);
    check("init_ovf", oovf, 0);
    check("init_read_en", read_en, 0);
    check("init_odata", odata, 0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single merge (3,5); abort with reset at address 1000.
    send_pair(3, 5);
    model_compute();
    check("model_r5", root_of[5], 3);
    check("model_r3", root_of[3], 3);
    finish = 1'b1;
    @(negedge clk);
    check("busy_run1", obusy, 1);
    pin_data(3, 3);
    pin_data(5, 3);
    pin_data(69, 3);
    mid_reset(1000);

    // Chain (2,4),(1,2),(3,4); late pair during scan must be dropped.
    send_pair(2, 4);
    send_pair(1, 2);
    send_pair(3, 4);
    model_compute();
    check("model_r4", root_of[4], 1);
    check("model_r3b", root_of[3], 1);
    finish = 1'b1;
    pin_data(2, 1);
    pin_data(4, 1);
    check("ovf_before_late", oovf, 0);
    resolve = 1'b1; lab1 = 6'd4; lab2 = 6'd9;
    @(negedge clk);
    resolve = 1'b0;
    @(negedge clk);
    check("ovf_late_pair", oovf, 1);
    mid_reset(300);

    // Ignored pairs, then nine pairs with the engine parked in IDLE; full scan.
    send_pair(0, 7);
    send_pair(5, 5);
    check("ovf_ignored", oovf, 0);
    send_pair(20, 40);
    send_pair(30, 40);
    send_pair(10, 40);
    send_pair(50, 60);
    send_pair(60, 63);
    send_pair(40, 63);
    send_pair(1, 9);
    send_pair(2, 9);
    check("ovf_eight", oovf, 0);
    send_pair(7, 8);
    check("ovf_ninth", oovf, 1);
    model_compute();
    check("model_r63", root_of[63], 10);
    check("model_r9", root_of[9], 1);
    check("model_r8", root_of[8], 8);
    vc0 = val_count;
    dc0 = done_count;
    finish = 1'b1;
    pin_data(8, 8);
    pin_data(63, 10);
    got = 0;
    for (int i = 0; i < NUM_PIX + 500; i++) begin
      @(negedge clk);
      if (odone) begin
        got = 1;
        break;
      end
    end
    if (!got) check("timeout_done", 0, 1);
    repeat (3) @(negedge clk);
    check("scan_val_count", val_count - vc0, NUM_PIX);
    check("scan_done_count", done_count - dc0, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_restart_busy", obusy, 0);
    end
    check("ovf_sticky", oovf, 1);

    // Fresh run without merges: table must be identity again after DONE.
    model_clear();
    model_compute();
    finish = 1'b0;
    @(negedge clk);
    finish = 1'b1;
    pin_data(63, 63);
    pin_data(72, 8);
    mid_reset(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
